// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one mem_system between instruction fetch (I, read-only) and data (D, read/write).
// One winner is captured, held stable downstream until Done, and the response is routed back to it.
module mem_arbiter #(
    parameter bit          PRIO_D  = 1'b0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        cache_hit,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_cache_hit,
    input  logic        m_err,
    output logic        err
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    port_t       grant;
    port_t       winner;
    logic [15:0] cap_addr;
    logic [15:0] cap_data;
    logic        cap_rd;
    logic        cap_wr;
    logic [7:0]  wdog;
    logic [15:0] i_data_q;
    logic [15:0] d_data_q;
    logic        err_q;

    logic req_i;
    logic req_d;
    logic capture;
    logic complete;
    logic timeout;
    logic err_set;

    assign req_i    = i_rd;
    assign req_d    = d_rd | d_wr;
    assign capture  = (state == IDLE) && (req_i || req_d);
    assign complete = (state == BUSY) && m_done;
    // A Done arriving in the final watchdog cycle still completes normally.
    assign timeout  = (state == BUSY) && !m_done && (wdog == WDOG_LAST);
    assign err_set  = m_err || ((state == IDLE) && d_rd && d_wr) || timeout;

    // grant doubles as last_grant: both are written only at capture.
    always_comb begin
        winner = PORT_I;
        if (req_i && req_d)
            winner = (PRIO_D || grant == PORT_I) ? PORT_D : PORT_I;
        else if (req_d)
            winner = PORT_D;
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (capture) next_state = BUSY;
            BUSY:    if (complete || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        cache_hit = 1'b0;
        if (state == BUSY) begin
            // Dropping Rd/Wr in the Done cycle keeps mem_system from starting a duplicate access.
            m_rd      = cap_rd & ~m_done;
            m_wr      = cap_wr & ~m_done;
            i_done    = m_done && (grant == PORT_I);
            d_done    = m_done && (grant == PORT_D);
            cache_hit = m_done & m_cache_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= PORT_I;
            cap_addr <= '0;
            cap_data <= '0;
            cap_rd   <= 1'b0;
            cap_wr   <= 1'b0;
            wdog     <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (capture) begin
                grant <= winner;
                wdog  <= '0;
                if (winner == PORT_D) begin
                    cap_addr <= d_addr;
                    cap_data <= d_data_in;
                    cap_rd   <= d_rd & ~d_wr;
                    cap_wr   <= d_wr;
                end else begin
                    cap_addr <= i_addr;
                    cap_data <= '0;
                    cap_rd   <= 1'b1;
                    cap_wr   <= 1'b0;
                end
            end else if (state == BUSY) begin
                wdog <= wdog + 8'd1;
            end

            if (complete && cap_rd) begin
                if (grant == PORT_I)
                    i_data_q <= m_data_out;
                else
                    d_data_q <= m_data_out;
            end

            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign m_addr     = cap_addr;
    assign m_data_in  = cap_data;
    assign i_data_out = i_data_q;
    assign d_data_out = d_data_q;
    assign err        = err_q;
    assign i_stall    = i_rd & ~i_done;
    assign d_stall    = (d_rd | d_wr) & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: instance 0 is round-robin (TIMEOUT 64), instance 1 is D-priority (TIMEOUT 8).
// Each instance talks to a behavioural mem_system stub; a transaction-level model predicts grants and data.
module tb_mem_arbiter;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]       i_rd, i_done, i_stall;
    logic [N-1:0][15:0] i_addr, i_data_out;
    logic [N-1:0]       d_rd, d_wr, d_done, d_stall;
    logic [N-1:0][15:0] d_addr, d_data_in, d_data_out;
    logic [N-1:0]       cache_hit, m_rd, m_wr, m_done, m_cache_hit, m_err, err;
    logic [N-1:0][15:0] m_addr, m_data_in, m_data_out;

    // Stub controls
    int           lat [N];
    bit [N-1:0]   never, hit, force_done, merr;

    // Reference model state
    int          lg [N];
    logic [15:0] mi [N];
    logic [15:0] md [N];
    logic [15:0] mm [N][256];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] init_val(logic [7:0] a);
        return 16'hBEEF ^ {a ^ 8'h40, a ^ 8'h40};
    endfunction

    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic         pend, wrq;
        int           cnt;
        logic [255:0] wmask;
        logic [15:0]  smem [256];
        logic [7:0]   sa;

        mem_arbiter #(.PRIO_D(g == 1), .TIMEOUT(g == 1 ? 8 : 64)) u_dut (
            .clk(clk), .rst(rst),
            .i_rd(i_rd[g]), .i_addr(i_addr[g]), .i_data_out(i_data_out[g]),
            .i_done(i_done[g]), .i_stall(i_stall[g]),
            .d_rd(d_rd[g]), .d_wr(d_wr[g]), .d_addr(d_addr[g]), .d_data_in(d_data_in[g]),
            .d_data_out(d_data_out[g]), .d_done(d_done[g]), .d_stall(d_stall[g]),
            .cache_hit(cache_hit[g]),
            .m_addr(m_addr[g]), .m_data_in(m_data_in[g]), .m_rd(m_rd[g]), .m_wr(m_wr[g]),
            .m_data_out(m_data_out[g]), .m_done(m_done[g]), .m_cache_hit(m_cache_hit[g]),
            .m_err(m_err[g]), .err(err[g])
        );

        assign sa             = m_addr[g][7:0];
        assign m_done[g]      = force_done[g] | (pend & ~never[g] & (cnt >= lat[g]));
        assign m_data_out[g]  = wmask[sa] ? smem[sa] : init_val(sa);
        assign m_cache_hit[g] = hit[g];
        assign m_err[g]       = merr[g];

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                pend  <= 1'b0;
                wrq   <= 1'b0;
                cnt   <= 0;
                wmask <= '0;
            end else if (m_done[g]) begin
                if (wrq) begin
                    smem[sa]  <= m_data_in[g];
                    wmask[sa] <= 1'b1;
                end
                pend <= 1'b0;
                wrq  <= 1'b0;
                cnt  <= 0;
            end else if (m_rd[g] | m_wr[g]) begin
                pend <= 1'b1;
                wrq  <= m_wr[g];
                cnt  <= cnt + 1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_rd = '0; d_rd = '0; d_wr = '0;
        i_addr = '0; d_addr = '0; d_data_in = '0;
        force_done = '0; merr = '0; never = '0; hit = '0;
        for (int g = 0; g < N; g++) lat[g] = 1;
    endtask

    function automatic void model_reset();
        for (int g = 0; g < N; g++) begin
            lg[g] = 0;
            mi[g] = '0;
            md[g] = '0;
            for (int a = 0; a < 256; a++) mm[g][a] = init_val(8'(a));
        end
    endfunction

    // Port chosen for a grant: 0 = I, 1 = D.
    function automatic int pick(int g, bit ri, bit rdq);
        if (ri && !rdq) return 0;
        if (rdq && !ri) return 1;
        if (g == 1) return 1;
        return (lg[g] == 0) ? 1 : 0;
    endfunction

    function automatic void model_complete(int g, int port, bit wr,
                                           logic [15:0] ia, logic [15:0] da, logic [15:0] dd);
        lg[g] = port;
        if (port == 0)
            mi[g] = mm[g][ia[7:0]];
        else if (wr)
            mm[g][da[7:0]] = dd;
        else
            md[g] = mm[g][da[7:0]];
    endfunction

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One request from each selected port, each held until its own done.
    task automatic serve(input int g, input bit ri, input bit rdq, input bit wrq,
                         input logic [15:0] ia, input logic [15:0] da, input logic [15:0] dd,
                         input int l);
        int first, nexp, got, kexp, port, exp_port;
        lat[g] = l;
        i_rd[g] = ri;  i_addr[g] = ia;
        d_rd[g] = rdq; d_wr[g] = wrq; d_addr[g] = da; d_data_in[g] = dd;
        nexp  = int'(ri) + int'(rdq | wrq);
        first = pick(g, ri, rdq | wrq);
        kexp  = 1 + l;
        got   = 0;
        for (int k = 1; k <= 100 && got < nexp; k++) begin
            tick();
            if (i_done[g] || d_done[g]) begin
                port     = d_done[g] ? 1 : 0;
                exp_port = (got == 0) ? first : 1 - first;
                chk("grant_port", port, exp_port);
                chk("done_latency", k, kexp);
                chk("single_done", {31'd0, i_done[g] & d_done[g]}, 0);
                chk("hit_qualified", {31'd0, cache_hit[g]}, {31'd0, hit[g]});
                chk("no_access_in_done", {31'd0, m_rd[g] | m_wr[g]}, 0);
                model_complete(g, exp_port, wrq, ia, da, dd);
                if (exp_port == 0) i_rd[g] = 1'b0;
                else begin d_rd[g] = 1'b0; d_wr[g] = 1'b0; end
                got++;
                kexp = k + 2 + l;
            end
        end
        chk("all_served", got, nexp);
        i_rd[g] = 1'b0; d_rd[g] = 1'b0; d_wr[g] = 1'b0;
        tick();
        chk("i_data_out", {16'd0, i_data_out[g]}, {16'd0, mi[g]});
        chk("d_data_out", {16'd0, d_data_out[g]}, {16'd0, md[g]});
        chk("err_clear", {31'd0, err[g]}, 0);
    endtask

    // Both ports read continuously; n grants are checked against the model.
    task automatic run_ties(input int g, input int n);
        int got, port, exp_port;
        logic [15:0] ia, da;
        ia = 16'h0003;
        da = 16'h0009;
        lat[g] = 1;
        i_rd[g] = 1'b1; i_addr[g] = ia;
        d_rd[g] = 1'b1; d_wr[g] = 1'b0; d_addr[g] = da;
        got = 0;
        for (int k = 1; k <= 100 && got < n; k++) begin
            tick();
            if (g == 1) chk("prio_i_stall_high", {31'd0, i_stall[g]}, 1);
            if (i_done[g] || d_done[g]) begin
                port     = d_done[g] ? 1 : 0;
                exp_port = pick(g, 1'b1, 1'b1);
                chk("tie_grant", port, exp_port);
                model_complete(g, exp_port, 1'b0, ia, da, 16'h0);
                got++;
            end
        end
        chk("ties_served", got, n);
        i_rd[g] = 1'b0; d_rd[g] = 1'b0;
        tick();
        chk("tie_i_data", {16'd0, i_data_out[g]}, {16'd0, mi[g]});
        chk("tie_d_data", {16'd0, d_data_out[g]}, {16'd0, md[g]});
    endtask

    initial begin
        bit seen;
        int pat;
        logic [15:0] ra, rb, rd;

        idle_inputs();
        model_reset();
        do_reset();

        // Reset state
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_m_rd%0d", g), {31'd0, m_rd[g]}, 0);
            chk($sformatf("rst_m_wr%0d", g), {31'd0, m_wr[g]}, 0);
            chk($sformatf("rst_done%0d", g), {30'd0, i_done[g], d_done[g]}, 0);
            chk($sformatf("rst_err%0d", g), {31'd0, err[g]}, 0);
            chk($sformatf("rst_i_data%0d", g), {16'd0, i_data_out[g]}, 0);
            chk($sformatf("rst_d_data%0d", g), {16'd0, d_data_out[g]}, 0);
            chk($sformatf("rst_m_addr%0d", g), {16'd0, m_addr[g]}, 0);
        end

        // m_done while IDLE is ignored
        force_done[0] = 1'b1; hit[0] = 1'b1;
        #1;
        chk("idle_done_i", {31'd0, i_done[0]}, 0);
        chk("idle_done_d", {31'd0, d_done[0]}, 0);
        chk("idle_done_hit", {31'd0, cache_hit[0]}, 0);
        tick();
        force_done[0] = 1'b0;
        chk("idle_done_data", {i_data_out[0], d_data_out[0]}, 0);

        // Hit path: I reads 0x0040 alone
        lat[0] = 1; hit[0] = 1'b1;
        i_rd[0] = 1'b1; i_addr[0] = 16'h0040;
        #1;
        chk("hit_idle_no_m_rd", {31'd0, m_rd[0]}, 0);
        chk("hit_i_stall", {31'd0, i_stall[0]}, 1);
        tick();
        chk("hit_m_rd_t1", {31'd0, m_rd[0]}, 1);
        chk("hit_m_addr", {16'd0, m_addr[0]}, 32'h0040);
        chk("hit_no_done_t1", {31'd0, i_done[0]}, 0);
        tick();
        chk("hit_i_done", {31'd0, i_done[0]}, 1);
        chk("hit_cache_hit", {31'd0, cache_hit[0]}, 1);
        chk("hit_m_rd_done", {31'd0, m_rd[0]}, 0);
        i_rd[0] = 1'b0;
        model_complete(0, 0, 1'b0, 16'h0040, 16'h0, 16'h0);
        tick();
        chk("hit_done_once", {31'd0, i_done[0]}, 0);
        chk("hit_i_data", {16'd0, i_data_out[0]}, 32'hBEEF);

        // Ties: round-robin from reset (D,I,D), then D-priority instance
        do_reset();
        run_ties(0, 3);
        run_ties(1, 3);

        // Write holding: D writes 0x1234 to 0x0100, I toggles, Done held off 20 cycles
        lat[0] = 20; hit[0] = 1'b0;
        d_wr[0] = 1'b1; d_addr[0] = 16'h0100; d_data_in[0] = 16'h1234;
        seen = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            tick();
            if (d_done[0]) begin
                seen = 1'b1;
                chk("wh_done_latency", k, 21);
                chk("wh_m_wr_done", {31'd0, m_wr[0]}, 0);
                chk("wh_hit", {31'd0, cache_hit[0]}, 0);
                d_wr[0] = 1'b0;
                i_rd[0] = 1'b0;
                model_complete(0, 1, 1'b1, 16'h0, 16'h0100, 16'h1234);
            end else begin
                chk("wh_m_addr", {16'd0, m_addr[0]}, 32'h0100);
                chk("wh_m_data_in", {16'd0, m_data_in[0]}, 32'h1234);
                chk("wh_m_wr", {30'd0, m_wr[0], m_rd[0]}, 32'h2);
                chk("wh_i_done", {31'd0, i_done[0]}, 0);
                i_rd[0] = k[0];
                i_addr[0] = 16'($urandom);
            end
        end
        chk("wh_seen_done", {31'd0, seen}, 1);
        tick();
        chk("wh_d_data_kept", {16'd0, d_data_out[0]}, {16'd0, md[0]});

        // Randomized rounds against the model
        for (int g = 0; g < N; g++) begin
            for (int r = 0; r < 25; r++) begin
                pat = $urandom_range(1, 3);
                hit[g] = 1'($urandom);
                ra = {8'($urandom), 8'($urandom_range(0, 15))};
                rb = {8'($urandom), 8'($urandom_range(0, 15))};
                rd = 16'($urandom);
                if (pat[1] && $urandom_range(0, 1) == 1)
                    serve(g, pat[0], 1'b0, 1'b1, ra, rb, rd, $urandom_range(1, 5));
                else
                    serve(g, pat[0], pat[1], 1'b0, ra, rb, rd, $urandom_range(1, 5));
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        // m_err sets sticky err
        merr[0] = 1'b1;
        tick();
        merr[0] = 1'b0;
        tick();
        chk("m_err_sticky", {31'd0, err[0]}, 1);

        // Asynchronous reset in the middle of an access
        lat[0] = 20;
        i_rd[0] = 1'b1; i_addr[0] = 16'h0005;
        tick(); tick(); tick();
        chk("pre_rst_m_rd", {31'd0, m_rd[0]}, 1);
        chk("pre_rst_i_data", {16'd0, i_data_out[0]}, {16'd0, mi[0]});
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_rd", {31'd0, m_rd[0]}, 0);
        chk("arst_m_wr", {31'd0, m_wr[0]}, 0);
        chk("arst_done", {30'd0, i_done[0], d_done[0]}, 0);
        chk("arst_err", {31'd0, err[0]}, 0);
        chk("arst_i_data", {16'd0, i_data_out[0]}, 0);
        chk("arst_d_data", {16'd0, d_data_out[0]}, 0);
        idle_inputs();
        model_reset();
        tick();
        rst = 1'b0;
        run_ties(0, 1);

        // d_rd and d_wr together: error, treated as a write
        chk("rdwr_err_before", {31'd0, err[0]}, 0);
        lat[0] = 1;
        d_rd[0] = 1'b1; d_wr[0] = 1'b1; d_addr[0] = 16'h0007; d_data_in[0] = 16'h5555;
        tick();
        chk("rdwr_err", {31'd0, err[0]}, 1);
        chk("rdwr_as_write", {30'd0, m_wr[0], m_rd[0]}, 32'h2);
        tick();
        chk("rdwr_d_done", {31'd0, d_done[0]}, 1);
        d_rd[0] = 1'b0; d_wr[0] = 1'b0;
        tick();
        chk("rdwr_d_data_kept", {16'd0, d_data_out[0]}, {16'd0, md[0]});

        // Watchdog on the TIMEOUT=8 instance
        chk("to_err_before", {31'd0, err[1]}, 0);
        never[1] = 1'b1;
        i_rd[1] = 1'b1; i_addr[1] = 16'h0020;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("to_busy_m_rd", {31'd0, m_rd[1]}, 1);
            chk("to_no_err_yet", {31'd0, err[1]}, 0);
            chk("to_no_done", {31'd0, i_done[1]}, 0);
        end
        tick();
        chk("to_err", {31'd0, err[1]}, 1);
        chk("to_idle", {31'd0, m_rd[1]}, 0);
        chk("to_no_done_after", {31'd0, i_done[1]}, 0);
        i_rd[1] = 1'b0;
        never[1] = 1'b0;
        tick();
        chk("to_stray_done_ignored", {31'd0, i_done[1]}, 0);
        chk("to_i_data_kept", {16'd0, i_data_out[1]}, {16'd0, mi[1]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
